// File: rtl/filt_sample_ctrl.sv
// filt_sample_ctrl: buffers a free-running XADC sample stream and sequences one
// start/done handshake per sample through the filters block.
module filt_sample_ctrl #(
  parameter int XADC_DATA_SIZE = 16,
  parameter int FIFO_ADDR_SIZE = 4,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XADC_DATA_SIZE-1:0] s_data,
  input  logic                      s_valid,
  input  logic [1:0]                sel_in,
  input  logic                      clr_flags,
  output logic                      filt_start,
  output logic [1:0]                filt_select,
  output logic [XADC_DATA_SIZE-1:0] input_val,
  input  logic [XADC_DATA_SIZE-1:0] filt_result,
  input  logic                      filt_done,
  output logic [XADC_DATA_SIZE-1:0] res_data,
  output logic                      res_valid,
  output logic [1:0]                res_sel,
  output logic                      busy,
  output logic [FIFO_ADDR_SIZE:0]   fifo_count,
  output logic                      ovf,
  output logic                      tmo
);

  localparam int DEPTH = 1 << FIFO_ADDR_SIZE;
  localparam int SCW   = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TOW   = $clog2(TIMEOUT + 1);

  localparam logic [FIFO_ADDR_SIZE:0]   CNT_FULL = (FIFO_ADDR_SIZE+1)'(DEPTH);
  localparam logic [FIFO_ADDR_SIZE:0]   CNT_ONE  = (FIFO_ADDR_SIZE+1)'(1);
  localparam logic [FIFO_ADDR_SIZE-1:0] PTR_ONE  = FIFO_ADDR_SIZE'(1);
  localparam logic [SCW-1:0]            SC_LAST  = SCW'(START_CYCLES - 1);
  localparam logic [SCW-1:0]            SC_ONE   = SCW'(1);
  localparam logic [TOW-1:0]            TO_LAST  = TOW'(TIMEOUT - 1);
  localparam logic [TOW-1:0]            TO_ONE   = TOW'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

  state_t                    state_q;
  logic [XADC_DATA_SIZE-1:0] mem_q [DEPTH];
  logic [FIFO_ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_SIZE:0]   count_q;
  logic [SCW-1:0]            st_cnt_q;
  logic [TOW-1:0]            to_cnt_q;
  logic                      filt_start_q, res_valid_q, ovf_q, tmo_q;
  logic [1:0]                filt_select_q, res_sel_q;
  logic [XADC_DATA_SIZE-1:0] input_val_q, res_data_q;

  logic full, empty, pop, push, drop, tmo_hit;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  // A done still high from a previous (or reset-aborted) transaction blocks the next start.
  assign pop     = (state_q == IDLE) && !empty && !filt_done;
  assign push    = s_valid && (!full || pop);
  assign drop    = s_valid && full && !pop;
  assign tmo_hit = (state_q == WAIT_DONE) && !filt_done && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: ;
      endcase
      if (drop)           ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
      if (tmo_hit)        tmo_q <= 1'b1;
      else if (clr_flags) tmo_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      st_cnt_q      <= '0;
      to_cnt_q      <= '0;
      filt_start_q  <= 1'b0;
      filt_select_q <= 2'b00;
      input_val_q   <= '0;
      res_data_q    <= '0;
      res_sel_q     <= 2'b00;
      res_valid_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          filt_start_q  <= 1'b0;
          filt_select_q <= (sel_in == 2'b11) ? 2'b00 : sel_in;
          if (pop) begin
            input_val_q  <= mem_q[rd_ptr_q];
            filt_start_q <= 1'b1;
            st_cnt_q     <= '0;
            state_q      <= START;
          end
        end
        START: begin
          if (st_cnt_q == SC_LAST) begin
            filt_start_q <= 1'b0;
            to_cnt_q     <= '0;
            state_q      <= WAIT_DONE;
          end else begin
            st_cnt_q <= st_cnt_q + SC_ONE;
          end
        end
        WAIT_DONE: begin
          if (filt_done) begin
            res_data_q  <= filt_result;
            res_sel_q   <= filt_select_q;
            res_valid_q <= 1'b1;
            state_q     <= RELEASE;
          end else if (tmo_hit) begin
            state_q <= RELEASE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        RELEASE: if (!filt_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign filt_start  = filt_start_q;
  assign filt_select = filt_select_q;
  assign input_val   = input_val_q;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_sel     = res_sel_q;
  assign busy        = (state_q != IDLE);
  assign fifo_count  = count_q;
  assign ovf         = ovf_q;
  assign tmo         = tmo_q;

endmodule

// File: tb/tb_filt_sample_ctrl.sv
// Randomized bench for filt_sample_ctrl: a queue-based sample/transaction model
// plus a behavioural filters responder with programmable latency.
module tb_filt_sample_ctrl;
  localparam int W = 16, AW = 4, DEPTH = 16, SC = 2, TO = 255;

  logic          clk = 1'b0, rst = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0, clr_flags = 1'b0;
  logic [1:0]    sel_in = 2'b00;
  logic          filt_start, res_valid, busy, ovf, tmo;
  logic [1:0]    filt_select, res_sel;
  logic [W-1:0]  input_val, res_data;
  logic [W-1:0]  filt_result = '0;
  logic          filt_done = 1'b0;
  logic [AW:0]   fifo_count;

  always #5 clk = ~clk;

  filt_sample_ctrl #(.XADC_DATA_SIZE(W), .FIFO_ADDR_SIZE(AW), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .sel_in(sel_in),
    .clr_flags(clr_flags), .filt_start(filt_start), .filt_select(filt_select),
    .input_val(input_val), .filt_result(filt_result), .filt_done(filt_done),
    .res_data(res_data), .res_valid(res_valid), .res_sel(res_sel), .busy(busy),
    .fifo_count(fifo_count), .ovf(ovf), .tmo(tmo)
  );

  typedef struct packed { logic [W-1:0] d; logic [1:0] s; } txn_t;

  int n_vec = 0, n_err = 0;
  logic [W-1:0] q_data[$];
  txn_t         txq[$];
  logic [1:0]   rs_log[$];
  logic ovf_m = 0, tmo_m = 0, prev_start = 0, pop_seen = 0;
  logic a_rst = 0, a_sv = 0, a_clr = 0, a_done = 0, a_done_d1 = 0;
  logic [W-1:0] a_data = '0;
  logic [1:0]   a_sel = '0;
  int start_len = 0, tmo_cd = 0, n_res = 0, n_acc = 0, n_drop = 0, n_to = 0;
  // filters responder
  bit fm_auto = 1, fm_never = 0, fm_wait = 0;
  int fm_lo = 10, fm_hi = 10, fm_cnt = 0, fm_hold = 0;
  logic [W-1:0] fm_in = '0;
  logic [1:0]   fm_sel = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ffun(input logic [W-1:0] x, input logic [1:0] s);
    logic [W-1:0] m;
    m = W'(s) + W'(1);
    return (x * m) ^ 16'h5A5A;
  endfunction

  task automatic chk_zero(input string tg);
    chk({tg, "_start"}, filt_start, 0);   chk({tg, "_fsel"}, filt_select, 0);
    chk({tg, "_ival"}, input_val, 0);     chk({tg, "_rdata"}, res_data, 0);
    chk({tg, "_rvalid"}, res_valid, 0);   chk({tg, "_rsel"}, res_sel, 0);
    chk({tg, "_busy"}, busy, 0);          chk({tg, "_count"}, fifo_count, 0);
    chk({tg, "_ovf"}, ovf, 0);            chk({tg, "_tmo"}, tmo, 0);
  endtask

  // One clock: record applied inputs, advance, check against the model, drive the responder.
  task automatic step();
    logic pop, fall, ovf_set, tmo_set, exp_rv;
    txn_t t;
    a_done_d1 = a_done;
    a_rst = rst; a_sv = s_valid; a_data = s_data; a_sel = sel_in; a_clr = clr_flags; a_done = filt_done;
    @(posedge clk); #1;
    pop = filt_start & ~prev_start;
    fall = ~filt_start & prev_start;
    pop_seen = 1'b0;
    if (!a_rst) begin
      q_data.delete(); txq.delete();
      ovf_m = 0; tmo_m = 0; tmo_cd = 0; start_len = 0; fm_wait = 0;
      prev_start = filt_start;
      return;
    end
    ovf_set = 0; tmo_set = 0;
    if (pop) begin
      pop_seen = 1'b1;
      chk("pop_nonempty", q_data.size() > 0, 1);
      if (q_data.size() > 0) begin
        t.d = q_data.pop_front();
        t.s = (a_sel == 2'b11) ? 2'b00 : a_sel;
        chk("input_val", input_val, t.d);
        chk("filt_select", filt_select, t.s);
        txq.push_back(t);
      end
    end
    if (a_sv) begin
      if (q_data.size() < DEPTH) begin q_data.push_back(a_data); n_acc++; end
      else begin ovf_set = 1; n_drop++; end
    end
    if (tmo_cd > 0) begin
      tmo_cd--;
      if (tmo_cd == 0) begin
        tmo_set = 1; n_to++;
        if (txq.size() > 0) t = txq.pop_front();
      end
    end
    if (ovf_set) ovf_m = 1; else if (a_clr) ovf_m = 0;
    if (tmo_set) tmo_m = 1; else if (a_clr) tmo_m = 0;
    chk("fifo_count", fifo_count, q_data.size());
    chk("ovf", ovf, ovf_m);
    chk("tmo", tmo, tmo_m);
    exp_rv = a_done & ~a_done_d1;
    chk("res_valid", res_valid, exp_rv);
    if (res_valid && exp_rv) begin
      chk("res_has_txn", txq.size() > 0, 1);
      if (txq.size() > 0) begin
        t = txq.pop_front(); n_res++;
        rs_log.push_back(res_sel);
        chk("res_data", res_data, ffun(t.d, t.s));
        chk("res_sel", res_sel, t.s);
      end
    end
    if (filt_start) start_len++;
    else if (fall) begin chk("start_len", start_len, SC); start_len = 0; end
    if (fm_auto) begin
      if (filt_start) begin fm_in = input_val; fm_sel = filt_select; end
      if (fall) begin
        if (fm_never) begin fm_never = 0; tmo_cd = TO; end
        else begin fm_wait = 1; fm_cnt = int'($urandom_range(fm_hi, fm_lo)) - 1; end
      end
      if (fm_wait) begin
        if (fm_cnt == 0) begin
          filt_done = 1'b1; filt_result = ffun(fm_in, fm_sel);
          fm_wait = 0; fm_hold = int'($urandom_range(3, 1));
        end else fm_cnt--;
      end else if (filt_done) begin
        fm_hold--;
        if (fm_hold <= 0) begin filt_done = 1'b0; filt_result = W'($urandom); end
      end
    end
    prev_start = filt_start;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    s_valid = 1'b0;
    while ((q_data.size() != 0 || txq.size() != 0 || busy || filt_done) && k < lim) begin
      step(); k++;
    end
    chk("drain_done", k < lim, 1);
    repeat (3) step();
  endtask

  initial begin
    int maxc, base_res, base_acc, fp_n, k;
    bit pp, full_now;

    step(); step();
    chk_zero("rst");
    rst = 1'b1;
    step();

    // single sample, fixed 10-cycle filter
    sel_in = 2'b00; s_data = 16'h1234; s_valid = 1'b1; step(); s_valid = 1'b0;
    chk("lat_t0", filt_start, 0);
    step(); chk("lat_t1", filt_start, 1); chk("lat_ival", input_val, 16'h1234);
    step(); chk("lat_t2", filt_start, 1);
    step(); chk("lat_t3", filt_start, 0);
    drain(200);
    chk("single_res", n_res, 1);

    // 50-sample burst against a 25-cycle filter
    fm_lo = 25; fm_hi = 25; base_res = n_res; base_acc = n_acc; maxc = 0;
    for (int i = 0; i < 50; i++) begin
      s_valid = 1'b1; s_data = W'($urandom); sel_in = 2'($urandom); step();
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    chk("burst_sat", maxc, DEPTH);
    chk("burst_ovf", ovf, 1);
    drain(3000);
    chk("burst_res", n_res - base_res, n_acc - base_acc);

    // select changes while waiting for done
    fm_lo = 20; fm_hi = 20; sel_in = 2'b00;
    s_valid = 1'b1; s_data = W'($urandom); step(); s_valid = 1'b0;
    repeat (3) step();
    sel_in = 2'b01; s_valid = 1'b1; s_data = W'($urandom); step(); s_valid = 1'b0;
    drain(300);
    chk("sel_old", rs_log[rs_log.size()-2], 0);
    chk("sel_new", rs_log[rs_log.size()-1], 1);
    sel_in = 2'b11; s_valid = 1'b1; s_data = W'($urandom); step(); s_valid = 1'b0;
    drain(300);
    chk("sel_rsv", rs_log[rs_log.size()-1], 0);

    // filter never answers the first of two samples
    fm_lo = 5; fm_hi = 10; fm_never = 1; base_res = n_res;
    s_valid = 1'b1; s_data = W'($urandom); step();
    s_data = W'($urandom); step(); s_valid = 1'b0;
    k = 0;
    while (!tmo && k < 400) begin step(); k++; end
    chk("tmo_seen", tmo, 1);
    drain(500);
    chk("tmo_next_res", n_res - base_res, 1);
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    chk("tmo_clr", tmo, 0); chk("ovf_clr", ovf, 0);

    // reset during START with done held high afterwards
    fm_auto = 0;
    s_valid = 1'b1; s_data = 16'hBEEF; step(); s_valid = 1'b0;
    step(); chk("pre_rst_start", filt_start, 1);
    rst = 1'b0; filt_done = 1'b1; filt_result = 16'hFFFF; step(); rst = 1'b1;
    chk_zero("midrst");
    s_valid = 1'b1; s_data = 16'h0F0F; step(); s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); chk("hold_start", filt_start, 0); chk("hold_busy", busy, 0);
    end
    filt_done = 1'b0; fm_auto = 1;
    step(); chk("rel_start", filt_start, 1);
    drain(200);

    // push into a full FIFO on the pop edge (one edge after done falls)
    fm_lo = 20; fm_hi = 20; fp_n = 0; k = 0;
    while (fp_n < 3 && k < 600) begin
      pp = !a_done && a_done_d1;
      full_now = (q_data.size() == DEPTH);
      s_valid = (q_data.size() < DEPTH) || pp; s_data = W'($urandom);
      step(); k++;
      if (pp && full_now) begin
        fp_n++;
        chk("fullpop_pop", pop_seen, 1);
        chk("fullpop_cnt", fifo_count, DEPTH);
        chk("fullpop_ovf", ovf, 0);
      end
    end
    chk("fullpop_seen", fp_n, 3);
    drain(1000);

    // random traffic
    fm_lo = 1; fm_hi = 30;
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(9, 0) < 3);
      s_data = W'($urandom);
      if ($urandom_range(7, 0) == 0) sel_in = 2'($urandom);
      clr_flags = ($urandom_range(49, 0) == 0);
      step();
    end
    clr_flags = 1'b0;
    drain(3000);
    chk("end_q", q_data.size(), 0);
    chk("end_txq", txq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
